// File: rtl/reg_access_sequencer.sv
// Sequences write / single-read / pair-read commands onto a two-read, one-write register file.
// Optional SAME_ADDR_MERGE_EN: a same-address pair read uses one read strobe instead of two.
module reg_access_sequencer #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4:0]            cmd_addr_a,
  input  logic [4:0]            cmd_addr_b,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data_a,
  output logic [DATA_WIDTH-1:0] rsp_data_b,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] din,
  output logic [4:0]            wad1,
  output logic [4:0]            rad1,
  output logic [4:0]            rad2,
  output logic                  wen1,
  output logic                  ren1,
  output logic                  ren2,
  input  logic [DATA_WIDTH-1:0] dout1,
  input  logic [DATA_WIDTH-1:0] dout2,
  input  logic                  collision
);

  typedef enum logic [2:0] {StIdle, StIssue, StIssueB, StWait, StResp} state_e;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPair  = 2'b10;

`ifdef SAME_ADDR_MERGE_EN
  localparam bit MergeEn = 1'b1;
`else
  localparam bit MergeEn = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [4:0]            addr_a_q, addr_a_d;
  logic [4:0]            addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  col_q, col_d;
  logic [DATA_WIDTH-1:0] rsp_data_a_q, rsp_data_a_d;
  logic [DATA_WIDTH-1:0] rsp_data_b_q, rsp_data_b_d;
  logic                  rsp_err_q, rsp_err_d;

  logic same_addr;
  logic is_read;
  logic split;

  assign same_addr = (addr_a_q == addr_b_q);
  assign is_read   = (op_q == OpRead) || (op_q == OpPair);
  // Same-address pair read without merging is serialised across ISSUE and ISSUE_B.
  assign split     = (op_q == OpPair) && same_addr && !MergeEn;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    wdata_d      = wdata_q;
    col_d        = col_q;
    rsp_data_a_d = rsp_data_a_q;
    rsp_data_b_d = rsp_data_b_q;
    rsp_err_d    = rsp_err_q;
    cmd_ready    = 1'b0;
    wen1         = 1'b0;
    ren1         = 1'b0;
    ren2         = 1'b0;
    wad1         = '0;
    rad1         = '0;
    rad2         = '0;
    din          = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d     = cmd_op;
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          wdata_d  = cmd_wdata;
          col_d    = 1'b0;
          state_d  = StIssue;
        end
      end

      StIssue: begin
        col_d = col_q | (is_read & collision);
        unique case (op_q)
          OpWrite: begin
            wen1    = 1'b1;
            wad1    = addr_a_q;
            din     = wdata_q;
            state_d = StIdle;
          end
          OpRead: begin
            ren1    = 1'b1;
            rad1    = addr_a_q;
            state_d = StWait;
          end
          OpPair: begin
            ren1 = 1'b1;
            rad1 = addr_a_q;
            if (!same_addr) begin
              ren2 = 1'b1;
              rad2 = addr_b_q;
            end
            state_d = split ? StIssueB : StWait;
          end
          default: state_d = StIdle;
        endcase
      end

      StIssueB: begin
        ren2         = 1'b1;
        rad2         = addr_b_q;
        col_d        = col_q | collision;
        // dout1 from the ISSUE strobe is only valid now, so take it here.
        rsp_data_a_d = dout1;
        state_d      = StWait;
      end

      StWait: begin
        rsp_err_d = col_q | collision;
        if (!split) begin
          rsp_data_a_d = dout1;
        end
        if (op_q == OpPair) begin
          rsp_data_b_d = (same_addr && !split) ? dout1 : dout2;
        end else begin
          rsp_data_b_d = '0;
        end
        state_d = StResp;
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      wdata_q      <= '0;
      col_q        <= 1'b0;
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      wdata_q      <= wdata_d;
      col_q        <= col_d;
      rsp_data_a_q <= rsp_data_a_d;
      rsp_data_b_q <= rsp_data_b_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign rsp_data_a = rsp_data_a_q;
  assign rsp_data_b = rsp_data_b_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: register-file model, response scoreboard, strobe monitor.
module tb_reg_access_sequencer;

  localparam int unsigned DW = 16;
`ifdef SAME_ADDR_MERGE_EN
  localparam int SameLat = 3;
  localparam logic SplitExp = 1'b0;
`else
  localparam int SameLat = 4;
  localparam logic SplitExp = 1'b1;
`endif
  localparam int BaseLat = 3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [4:0]    cmd_addr_a, cmd_addr_b;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic [DW-1:0] din, dout1, dout2;
  logic [4:0]    wad1, rad1, rad2;
  logic          wen1, ren1, ren2, collision;

  logic [DW-1:0] mem    [32];
  logic [DW-1:0] shadow [32];
  rsp_t          exp_q  [$];
  rsp_t          e;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_access_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_err    (rsp_err),
    .din        (din),
    .wad1       (wad1),
    .rad1       (rad1),
    .rad2       (rad2),
    .wen1       (wen1),
    .ren1       (ren1),
    .ren2       (ren2),
    .dout1      (dout1),
    .dout2      (dout2),
    .collision  (collision)
  );

  // Register file: read data valid for exactly one cycle after the strobe.
  always @(posedge clk) begin
    if (wen1) mem[wad1] <= din;
    dout1 <= ren1 ? mem[rad1] : '0;
    dout2 <= ren2 ? mem[rad2] : '0;
  end

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (wen1 && (ren1 || ren2)) begin
        n_fail++; $display("FAIL strobe_excl: wen1=%b ren1=%b ren2=%b", wen1, ren1, ren2);
      end
      if (ren1 && ren2 && (rad1 == rad2)) begin
        n_fail++; $display("FAIL same_addr_dual: rad1=%0d rad2=%0d both strobed", rad1, rad2);
      end
      if (rsp_valid && rsp_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got a=%h b=%h err=%b, none expected",
                   rsp_data_a, rsp_data_b, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data_a, rsp_data_b, rsp_err} !== e) begin
            n_fail++;
            $display("FAIL rsp_data: got a=%h b=%h err=%b, expected a=%h b=%h err=%b",
                     rsp_data_a, rsp_data_b, rsp_err, e.a, e.b, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Presents a command and returns the cycle count of its accepting edge.
  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [DW-1:0] wd, output int acc);
    int g;
    g = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = wd;
    @(negedge clk);
    while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++; $display("FAIL accept: got cmd_ready=0, expected 1");
    end
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Called at a negedge; waits for rsp_valid and checks latency from the accepting edge.
  task automatic wait_rsp(input int acc, input int lat, input string name);
    int g;
    g = 0;
    while (!rsp_valid && g < 20) begin @(negedge clk); g++; end
    n_tests++;
    if (!rsp_valid) begin
      n_fail++; $display("FAIL %s_timeout: got no rsp_valid, expected one", name);
    end else if (cyc - acc + 1 != lat) begin
      n_fail++; $display("FAIL %s_latency: got N+%0d, expected N+%0d", name, cyc - acc + 1, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; collision = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", rsp_valid); end
    n_tests++; if ({rsp_data_a, rsp_data_b, rsp_err} !== '0) begin
      n_fail++; $display("FAIL rst_rsp: got a=%h b=%h err=%b expected 0", rsp_data_a, rsp_data_b, rsp_err);
    end
    n_tests++; if ({wen1, ren1, ren2} !== 3'b000) begin
      n_fail++; $display("FAIL rst_strobes: got %b expected 000", {wen1, ren1, ren2});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write(input logic [4:0] a, input logic [DW-1:0] wd);
    int acc;
    send(2'b00, a, 5'd0, wd, acc);
    shadow[a] = wd;
    @(negedge clk);
    n_tests++; if ({wen1, wad1, din} !== {1'b1, a, wd}) begin
      n_fail++; $display("FAIL wr_issue: got wen1=%b wad1=%0d din=%h expected 1 %0d %h", wen1, wad1, din, a, wd);
    end
    @(negedge clk);
    n_tests++; if ({wen1, cmd_ready, rsp_valid} !== 3'b010) begin
      n_fail++; $display("FAIL wr_after: got wen1/ready/valid=%b expected 010", {wen1, cmd_ready, rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read(input logic [4:0] a);
    int acc;
    exp_q.push_back('{a: shadow[a], b: '0, err: 1'b0});
    send(2'b01, a, 5'd0, '0, acc);
    @(negedge clk);
    n_tests++; if ({ren1, ren2, rad1} !== {2'b10, a}) begin
      n_fail++; $display("FAIL rd_issue: got ren1=%b ren2=%b rad1=%0d expected 1 0 %0d", ren1, ren2, rad1, a);
    end
    wait_rsp(acc, BaseLat, "rd");
  endtask

  task automatic test_pair_read(input logic [4:0] a, input logic [4:0] b);
    int acc;
    exp_q.push_back('{a: shadow[a], b: shadow[b], err: 1'b0});
    send(2'b10, a, b, '0, acc);
    @(negedge clk);
    n_tests++; if ({ren1, ren2, rad1, rad2} !== {2'b11, a, b}) begin
      n_fail++; $display("FAIL pair_issue: got ren=%b rad1=%0d rad2=%0d expected 11 %0d %0d",
                         {ren1, ren2}, rad1, rad2, a, b);
    end
    wait_rsp(acc, BaseLat, "pair");
  endtask

  task automatic test_same_addr(input logic [4:0] a);
    int acc;
    exp_q.push_back('{a: shadow[a], b: shadow[a], err: 1'b0});
    send(2'b10, a, a, '0, acc);
    @(negedge clk);
    n_tests++; if ({ren1, ren2, rad1} !== {2'b10, a}) begin
      n_fail++; $display("FAIL same_issue: got ren=%b rad1=%0d expected 10 %0d", {ren1, ren2}, rad1, a);
    end
    @(negedge clk);
    n_tests++; if ({ren1, ren2, rad2} !== {1'b0, SplitExp, SplitExp ? a : 5'd0}) begin
      n_fail++; $display("FAIL same_issue_b: got ren=%b rad2=%0d expected %b", {ren1, ren2}, rad2, {1'b0, SplitExp});
    end
    wait_rsp(acc, SameLat, "same");
  endtask

  task automatic test_backpressure(input logic [4:0] a);
    int acc;
    rsp_ready = 1'b0;
    exp_q.push_back('{a: shadow[a], b: '0, err: 1'b0});
    send(2'b01, a, 5'd0, '0, acc);
    @(negedge clk);
    wait_rsp(acc, BaseLat, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, cmd_ready, rsp_data_a, rsp_data_b, rsp_err} !== {2'b10, shadow[a], {DW{1'b0}}, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b ready=%b a=%h b=%h err=%b expected 1 0 %h 0 0",
                           i, rsp_valid, cmd_ready, rsp_data_a, rsp_data_b, rsp_err, shadow[a]);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_collision(input logic [4:0] a);
    int acc;
    exp_q.push_back('{a: shadow[a], b: '0, err: 1'b1});
    send(2'b01, a, 5'd0, '0, acc);
    @(posedge clk); #1 collision = 1'b1;
    @(posedge clk); #1 collision = 1'b0;
    @(negedge clk);
    wait_rsp(acc, BaseLat, "col");
    // A write under collision yields nothing, and a clean read afterwards has no error.
    collision = 1'b1;
    test_write(5'd9, 16'h5A5A);
    collision = 1'b0;
    test_single_read(5'd9);
  endtask

  task automatic test_reset_mid(input logic [4:0] a);
    int acc;
    send(2'b01, a, 5'd0, '0, acc);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if ({ren1, ren2, cmd_ready, rsp_valid} !== 4'b0010) begin
      n_fail++; $display("FAIL rstmid_strobes: got ren1/ren2/ready/valid=%b expected 0010",
                         {ren1, ren2, cmd_ready, rsp_valid});
    end
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++; if ({rsp_valid, ren1, ren2, cmd_ready} !== 4'b0001) begin
        n_fail++; $display("FAIL rstmid_idle%0d: got valid/ren1/ren2/ready=%b expected 0001",
                           i, {rsp_valid, ren1, ren2, cmd_ready});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved();
    int acc;
    send(2'b11, 5'd3, 5'd7, 16'hFFFF, acc);
    @(negedge clk);
    n_tests++; if ({wen1, ren1, ren2} !== 3'b000) begin
      n_fail++; $display("FAIL rsvd_strobes: got %b expected 000", {wen1, ren1, ren2});
    end
    repeat (4) @(negedge clk);
    n_tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL rsvd_idle: got ready/valid=%b expected 10", {cmd_ready, rsp_valid});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write(5'd3, 16'h1234);
    test_write(5'd7, 16'hBEEF);
    test_write(5'd5, 16'h0A5A);
    test_single_read(5'd3);
    test_pair_read(5'd3, 5'd7);
    test_pair_read(5'd7, 5'd5);
    test_same_addr(5'd5);
    test_backpressure(5'd7);
    test_collision(5'd3);
    test_reset_mid(5'd3);
    test_reserved();
    test_single_read(5'd7);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_rsp: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
